hex_display_ctrl: RTL and testbench
===================================

Name: hex_display_ctrl

Overview:
- Downstream consumer of the top-level core wrapper. Drives the eight 7-segment digits from the PC value and the monitor state.
- Samples a 32-bit value at a human-readable rate and holds it stable between samples.
- Freezes the last value on halt. On error, shows the exception code as a blinking fault pattern.
- Registered outputs; runs on the PLL clock domain.

Parameters:
- HOLD_CYCLES, 5000000, clocks between live samples of value_i (must be >= 1).
- BLINK_CYCLES, 12500000, clocks per on/off phase of the fault blink (must be >= 1).

Ports:
- clk_i  input  1  PLL clock.
- rst_i  input  1  reset, asynchronous, active-low.
- value_i  input  32  value to display (PC low word).
- valid_i  input  1  value_i may be sampled this cycle.
- mode_i  input  2  monitor state: 0=RST, 1=NORMAL, 2=HALT, 3=ERROR.
- code_i  input  8  exception code vector.
- segs_o  output  56  digit k on bits [7k+6:7k]; bit0=a … bit6=g; active-low.
- update_o  output  1  one-cycle pulse when the shadow register loads.

Behaviour:
- Reset (rst_i=0, async):
  - state=BLANK; shadow=0; code_r=0.
  - hold_cnt=0; blink_cnt=0; blink_on=1.
  - segs_o=all 1s (blank); update_o=0.
- Glyphs, hex 0-F, standard active-low patterns:
  - 0=7'b1000000, 1=7'b1111001, 8=7'b0000000, F=7'b0001110.
  - blank=7'b1111111.
  - fault glyph (segments a,d,g lit)=7'b0110110.
- States, evaluated each clock in priority order:
  - Any state, mode_i=RST -> BLANK. Counters cleared; shadow kept.
  - BLANK, mode_i=NORMAL -> LIVE. hold_cnt=0.
  - LIVE, FROZEN or BLANK, mode_i=ERROR -> FAULT. code_r<=code_i in the same cycle; blink_cnt=0; blink_on=1.
  - LIVE or BLANK, mode_i=HALT -> FROZEN. shadow<=value_i unconditionally in the same cycle (ignores valid_i). update_o pulses.
  - FROZEN, mode_i=NORMAL -> LIVE. hold_cnt=0.
  - FAULT is sticky: leaves only via mode_i=RST or rst_i.
- LIVE sampling:
  - hold_cnt counts 0..HOLD_CYCLES-1 and wraps.
  - At terminal count with valid_i=1: shadow<=value_i and update_o=1 next cycle.
  - At terminal count with valid_i=0: no load; the counter still wraps (sample skipped, not deferred).
  - HOLD_CYCLES=1: sample every cycle that valid_i=1.
- Simultaneous events: a mode transition and a terminal tick in the same cycle -> the transition wins and the tick is discarded. The only load that cycle is the HALT capture.
- Output mapping, registered (segs_o reflects state/shadow one clock after they change):
  - BLANK: all digits blank.
  - LIVE / FROZEN: digit k = hex(shadow[4k+3:4k]).
  - FAULT, blink_on=1: digits 7..2 = fault glyph; digit1 = hex(code_r[7:4]); digit0 = hex(code_r[3:0]).
  - FAULT, blink_on=0: all digits blank.
  - FAULT: blink_cnt counts 0..BLINK_CYCLES-1; blink_on toggles at each wrap.
- Latency:
  - value_i sampled at terminal tick N -> update_o high at N+1, segs_o updated at N+1.
  - Mode change at cycle M -> new pattern on segs_o at M+1.
- Counter widths: $clog2 of the parameter, minimum 1 bit. No overflow beyond the terminal value.
- Reset mid-operation: async clear regardless of state or counters. Outputs go blank immediately, not on the next clock.

Test Plan (HOLD_CYCLES=4, BLINK_CYCLES=3):
- Reset then mode_i=NORMAL, valid_i=1, value_i=0x80000000 -> update_o pulses every 4 clocks; segs_o digit7=7'b0000000 ('8'), digits 6..0=7'b1000000 ('0').
- LIVE, valid_i=0 on a terminal tick, value_i=0x12345678 -> no update_o that period; display keeps the old value; next tick with valid_i=1 loads 0x12345678.
- mode_i=HALT while value_i=0x80000004, mid hold period -> shadow=0x80000004 next cycle, update_o=1. Changing value_i afterwards leaves segs_o unchanged. mode_i=NORMAL resumes sampling 4 clocks later.
- mode_i=ERROR, code_i=0x05 -> digits7..2=7'b0110110, digit1='0', digit0='5'. All-blank for 3 clocks, then back on, repeating. mode_i=NORMAL has no effect; mode_i=RST blanks.
- mode_i=HALT and a LIVE terminal tick in the same cycle -> exactly one update_o pulse, shadow=HALT-cycle value_i.
- rst_i low for one cycle during FAULT, between clock edges -> segs_o all 1s before the next edge; state BLANK; update_o=0.

Source files
------------

// File: rtl/hex_display_ctrl.sv
// Eight-digit 7-segment driver: rate-limited live sampling, halt freeze, blinking fault code.
// Registered outputs; a state or shadow change reaches segs_o one clock later. No backpressure.
module hex_display_ctrl #(
  parameter int HOLD_CYCLES  = 5000000,
  parameter int BLINK_CYCLES = 12500000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] value_i,
  input  logic        valid_i,
  input  logic [1:0]  mode_i,
  input  logic [7:0]  code_i,
  output logic [55:0] segs_o,
  output logic        update_o
);

  localparam int HW = (HOLD_CYCLES  > 1) ? $clog2(HOLD_CYCLES)  : 1;
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

  localparam logic [1:0] MODE_RST   = 2'd0;
  localparam logic [1:0] MODE_HALT  = 2'd2;
  localparam logic [1:0] MODE_ERROR = 2'd3;

  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
  localparam logic [6:0] GLYPH_FAULT = 7'b0110110;

  typedef enum logic [1:0] {
    ST_BLANK  = 2'd0,
    ST_LIVE   = 2'd1,
    ST_FROZEN = 2'd2,
    ST_FAULT  = 2'd3
  } state_e;

  state_e          state_q,     state_d;
  logic [31:0]     shadow_q,    shadow_d;
  logic [7:0]      code_q,      code_d;
  logic [HW-1:0]   hold_q,      hold_d;
  logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
  logic            blink_on_q,  blink_on_d;
  logic [55:0]     segs_q,      segs_d;
  logic            update_q,    update_d;
  logic            load_d;

  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;
      4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    return g;
  endfunction

  // Async clear also blanks segs_q, so the display goes dark without waiting for a clock.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_BLANK;
      shadow_q    <= '0;
      code_q      <= '0;
      hold_q      <= '0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      segs_q      <= '1;
      update_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      code_q      <= code_d;
      hold_q      <= hold_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      segs_q      <= segs_d;
      update_q    <= update_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    code_d      = code_q;
    hold_d      = hold_q;
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    load_d      = 1'b0;
    if (mode_i == MODE_RST) begin
      state_d     = ST_BLANK;
      hold_d      = '0;
      blink_cnt_d = '0;
      blink_on_d  = 1'b1;
    end else if (state_q == ST_FAULT) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_on_d  = ~blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end else begin
      case (mode_i)
        MODE_ERROR: begin
          state_d     = ST_FAULT;
          code_d      = code_i;
          blink_cnt_d = '0;
          blink_on_d  = 1'b1;
        end
        // A transition in the same cycle as a terminal tick swallows the tick.
        MODE_HALT: begin
          if (state_q != ST_FROZEN) begin
            state_d  = ST_FROZEN;
            shadow_d = value_i;
            hold_d   = '0;
            load_d   = 1'b1;
          end
        end
        default: begin
          if (state_q == ST_LIVE) begin
            if (hold_q == HOLD_LAST) begin
              hold_d = '0;
              if (valid_i) begin
                shadow_d = value_i;
                load_d   = 1'b1;
              end
            end else begin
              hold_d = hold_q + HW'(1);
            end
          end else begin
            state_d = ST_LIVE;
            hold_d  = '0;
          end
        end
      endcase
    end
  end

  always_comb begin
    segs_d   = {8{GLYPH_BLANK}};
    update_d = load_d;
    case (state_d)
      ST_LIVE, ST_FROZEN: begin
        for (int k = 0; k < 8; k++) begin
          segs_d[7*k +: 7] = hex_glyph(shadow_d[4*k +: 4]);
        end
      end
      ST_FAULT: begin
        if (blink_on_d) begin
          for (int k = 2; k < 8; k++) begin
            segs_d[7*k +: 7] = GLYPH_FAULT;
          end
          segs_d[13:7] = hex_glyph(code_d[7:4]);
          segs_d[6:0]  = hex_glyph(code_d[3:0]);
        end
      end
      default: segs_d = {8{GLYPH_BLANK}};
    endcase
  end

  assign segs_o   = segs_q;
  assign update_o = update_q;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Bench for hex_display_ctrl with short hold/blink periods; per-cycle scoreboard plus directed pattern checks.
module tb_hex_display_ctrl;

  localparam int H = 4;
  localparam int B = 3;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] value_i;
  logic        valid_i;
  logic [1:0]  mode_i;
  logic [7:0]  code_i;
  logic [55:0] segs_o;
  logic        update_o;

  hex_display_ctrl #(.HOLD_CYCLES(H), .BLINK_CYCLES(B)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .value_i  (value_i),
    .valid_i  (valid_i),
    .mode_i   (mode_i),
    .code_i   (code_i),
    .segs_o   (segs_o),
    .update_o (update_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;
  int upd_seen = 0;

  logic [55:0] exp_segs_q[$];
  logic        exp_upd_q[$];

  // Reference state: 0=BLANK 1=LIVE 2=FROZEN 3=FAULT
  int          m_state;
  logic [31:0] m_shadow;
  logic [7:0]  m_code;
  int          m_hold;
  int          m_bcnt;
  logic        m_bon;

  localparam logic [55:0] ALL_BLANK = {8{7'b1111111}};
  localparam logic [6:0]  FG = 7'b0110110;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] hexg(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
          7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
          7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
          7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    return t[n];
  endfunction

  function automatic logic [55:0] pack_hex(input logic [31:0] v);
    logic [55:0] r;
    for (int k = 0; k < 8; k++) r[7*k +: 7] = hexg(v[4*k +: 4]);
    return r;
  endfunction

  task automatic model_reset();
    m_state = 0; m_shadow = '0; m_code = '0;
    m_hold = 0; m_bcnt = 0; m_bon = 1'b1;
    exp_segs_q.delete();
    exp_upd_q.delete();
  endtask

  // Advance the reference by one clock using the inputs now applied; queue what the DUT must show after the edge.
  task automatic model_tick();
    logic        upd;
    logic [55:0] s;
    upd = 1'b0;
    if (mode_i == 2'd0) begin
      m_state = 0; m_hold = 0; m_bcnt = 0; m_bon = 1'b1;
    end else if (m_state == 3) begin
      m_bcnt++;
      if (m_bcnt == B) begin m_bcnt = 0; m_bon = !m_bon; end
    end else if (mode_i == 2'd3) begin
      m_state = 3; m_code = code_i; m_bcnt = 0; m_bon = 1'b1;
    end else if (mode_i == 2'd2) begin
      if (m_state != 2) begin m_state = 2; m_shadow = value_i; upd = 1'b1; m_hold = 0; end
    end else if (m_state == 1) begin
      if (m_hold == H - 1) begin
        m_hold = 0;
        if (valid_i) begin m_shadow = value_i; upd = 1'b1; end
      end else m_hold++;
    end else begin
      m_state = 1; m_hold = 0;
    end
    if (m_state == 1 || m_state == 2) s = pack_hex(m_shadow);
    else if (m_state == 3 && m_bon) s = {{6{FG}}, hexg(m_code[7:4]), hexg(m_code[3:0])};
    else s = ALL_BLANK;
    exp_segs_q.push_back(s);
    exp_upd_q.push_back(upd);
  endtask

  task automatic step();
    logic [55:0] es;
    logic        eu;
    model_tick();
    @(posedge clk_i);
    #1;
    es = exp_segs_q.pop_front();
    eu = exp_upd_q.pop_front();
    chk_eq("segs", segs_o, es);
    chk_eq("update", update_o, eu);
    if (update_o) upd_seen++;
    @(negedge clk_i);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst_i = 1'b0; mode_i = 2'd0; valid_i = 1'b0; value_i = '0; code_i = '0;
    model_reset();
    repeat (2) @(negedge clk_i);
    chk_eq("rst_segs", segs_o, ALL_BLANK);
    chk_eq("rst_upd", update_o, 1'b0);
    rst_i = 1'b1;
    run(2);

    mode_i = 2'd1; valid_i = 1'b1; value_i = 32'h8000_0000;
    upd_seen = 0;
    run(10);
    chk_eq("live_80", segs_o, {7'b0000000, {7{7'b1000000}}});
    chk_eq("live_npulse", upd_seen, 2);

    value_i = 32'h1234_5678; valid_i = 1'b0; upd_seen = 0;
    run(4);
    chk_eq("skip_npulse", upd_seen, 0);
    chk_eq("skip_hold", segs_o, {7'b0000000, {7{7'b1000000}}});
    valid_i = 1'b1;
    run(4);
    chk_eq("load_1234", segs_o, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000});

    for (int i = 0; i < 8 && m_hold != 1; i++) step();
    value_i = 32'h8000_0004; mode_i = 2'd2;
    step();
    chk_eq("halt_upd", update_o, 1'b1);
    chk_eq("halt_segs", segs_o, {7'b0000000, {6{7'b1000000}}, 7'b0011001});
    value_i = 32'hFFFF_FFFF;
    run(5);
    chk_eq("frozen_hold", segs_o, {7'b0000000, {6{7'b1000000}}, 7'b0011001});

    mode_i = 2'd1; value_i = 32'h0000_ABCD; upd_seen = 0;
    run(4);
    chk_eq("resume_early", upd_seen, 0);
    run(1);
    chk_eq("resume_load", upd_seen, 1);

    for (int i = 0; i < 8 && m_hold != H - 1; i++) step();
    value_i = 32'hDEAD_BEEF; mode_i = 2'd2; upd_seen = 0;
    run(4);
    chk_eq("coinc_npulse", upd_seen, 1);
    chk_eq("coinc_segs", segs_o, pack_hex(32'hDEAD_BEEF));

    code_i = 8'h05; mode_i = 2'd3;
    step();
    chk_eq("fault_on", segs_o, {{6{7'b0110110}}, 7'b1000000, 7'b0010010});
    mode_i = 2'd1;
    run(2);
    chk_eq("fault_still_on", segs_o, {{6{7'b0110110}}, 7'b1000000, 7'b0010010});
    run(1);
    chk_eq("fault_off", segs_o, ALL_BLANK);
    run(3);
    chk_eq("fault_on_again", segs_o, {{6{7'b0110110}}, 7'b1000000, 7'b0010010});
    mode_i = 2'd2;
    run(6);
    mode_i = 2'd0;
    step();
    chk_eq("fault_rst", segs_o, ALL_BLANK);

    code_i = 8'hA7; mode_i = 2'd3;
    run(4);
    rst_i = 1'b0;
    #1;
    chk_eq("arst_segs", segs_o, ALL_BLANK);
    chk_eq("arst_upd", update_o, 1'b0);
    model_reset();
    @(posedge clk_i);
    #1;
    chk_eq("arst_hold", segs_o, ALL_BLANK);
    @(negedge clk_i);
    rst_i = 1'b1; mode_i = 2'd1; value_i = 32'h0F0F_0F0F;
    step();
    chk_eq("post_rst_live", segs_o, {8{7'b1000000}});
    run(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
